// File: rtl/serial_subtractor.sv
// Digit-serial subtractor: a - b - bin, DIGIT bits per clock, borrow carried in a register.
// Valid/ready on both sides; outputs hold the last completed result until the next one.

module serial_subtractor_fs (
    input  logic a_i,
    input  logic b_i,
    input  logic br_i,
    output logic d_o,
    output logic br_o
);
    assign d_o  = a_i ^ b_i ^ br_i;
    assign br_o = (~a_i & b_i) | (~(a_i ^ b_i) & br_i);
endmodule

module serial_subtractor #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] d,
    output logic             bout,
    output logic             zero
);
    localparam int K  = WIDTH / DIGIT;
    localparam int CW = (K > 1) ? $clog2(K) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q, b_q, res_d, d_q;
    logic             br_q, bout_q, zero_q;
    logic [CW-1:0]    cnt_q;
    logic [DIGIT:0]   br_c;
    logic [DIGIT-1:0] dig;

    assign br_c[0] = br_q;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        serial_subtractor_fs u_fs (
            .a_i  (a_q[i]),
            .b_i  (b_q[i]),
            .br_i (br_c[i]),
            .d_o  (dig[i]),
            .br_o (br_c[i+1])
        );
    end

    // a_q doubles as the result register: minuend digits leave at the bottom
    // while difference digits enter at the top, so after K steps it holds d.
    if (K == 1) begin : g_one
        assign res_d = dig;
    end else begin : g_multi
        assign res_d = {dig, a_q[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    a_q     <= a;
                    b_q     <= b;
                    br_q    <= bin;
                    cnt_q   <= '0;
                    state_q <= RUN;
                end
                RUN: begin
                    a_q   <= res_d;
                    b_q   <= b_q >> DIGIT;
                    br_q  <= br_c[DIGIT];
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == CW'(K - 1)) begin
                        d_q     <= res_d;
                        bout_q  <= br_c[DIGIT];
                        zero_q  <= (res_d == '0);
                        state_q <= DONE;
                    end
                end
                DONE: if (out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign d         = d_q;
    assign bout      = bout_q;
    assign zero      = zero_q;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed + exhaustive bench for serial_subtractor over four WIDTH/DIGIT configurations.

module tb_serial_subtractor;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // index 0: W8/D1, 1: W8/D4, 2: W3/D1, 3: W3/D3
    logic       iv  [4];
    logic       orr [4];
    logic       ir  [4];
    logic       ov  [4];
    logic [7:0] ta  [4];
    logic [7:0] tb  [4];
    logic       tbi [4];
    logic [7:0] od  [4];
    logic       obo [4];
    logic       oz  [4];
    logic [2:0] d2, d3;
    assign od[2] = {5'b0, d2};
    assign od[3] = {5'b0, d3};

    int kk [4] = '{8, 2, 3, 1};
    int checks = 0;
    int errors = 0;
    logic [9:0] sb_q [$];

    serial_subtractor #(.WIDTH(8), .DIGIT(1)) u0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]), .a(ta[0]), .b(tb[0]),
        .bin(tbi[0]), .out_valid(ov[0]), .out_ready(orr[0]), .d(od[0]), .bout(obo[0]), .zero(oz[0]));
    serial_subtractor #(.WIDTH(8), .DIGIT(4)) u1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]), .a(ta[1]), .b(tb[1]),
        .bin(tbi[1]), .out_valid(ov[1]), .out_ready(orr[1]), .d(od[1]), .bout(obo[1]), .zero(oz[1]));
    serial_subtractor #(.WIDTH(3), .DIGIT(1)) u2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]), .a(ta[2][2:0]), .b(tb[2][2:0]),
        .bin(tbi[2]), .out_valid(ov[2]), .out_ready(orr[2]), .d(d2), .bout(obo[2]), .zero(oz[2]));
    serial_subtractor #(.WIDTH(3), .DIGIT(3)) u3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(ir[3]), .a(ta[3][2:0]), .b(tb[3][2:0]),
        .bin(tbi[3]), .out_valid(ov[3]), .out_ready(orr[3]), .d(d3), .bout(obo[3]), .zero(oz[3]));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: integer arithmetic, independent of any bit-serial structure.
    function automatic logic [9:0] model(input int s, input logic [7:0] a, input logic [7:0] b,
                                        input logic bi);
        int m, diff;
        logic [7:0] dd;
        m    = (s < 2) ? 255 : 7;
        diff = int'(a) - int'(b) - int'(bi);
        dd   = 8'(diff & m);
        return {dd, (diff < 0), (dd == 8'h00)};
    endfunction

    task automatic do_op(input int s, input logic [7:0] a, input logic [7:0] b, input logic bi,
                         input int stall, input bit toggle);
        int n, lat;
        logic [7:0] m, hd;
        logic hb, hz;
        logic [9:0] e;
        m = (s < 2) ? 8'hFF : 8'h07;
        n = 0;
        while (!ir[s] && n < 100) begin @(negedge clk); n++; end
        chk("in_ready_wait", 32'(ir[s]), 32'd1);
        ta[s] = a & m; tb[s] = b & m; tbi[s] = bi; iv[s] = 1'b1; orr[s] = (stall == 0);
        sb_q.push_back(model(s, a & m, b & m, bi));
        @(negedge clk);
        iv[s] = 1'b0;
        chk("in_ready_run", 32'(ir[s]), 32'd0);
        lat = 0;
        while (!ov[s] && lat < 50) begin
            if (toggle) begin
                ta[s] = 8'($urandom) & m; tb[s] = 8'($urandom) & m; tbi[s] = 1'($urandom);
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(kk[s]));
        hd = od[s]; hb = obo[s]; hz = oz[s];
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_d", {od[s], obo[s], oz[s], ov[s], ir[s]}, {hd, hb, hz, 1'b1, 1'b0});
        end
        orr[s] = 1'b1;
        e = sb_q.pop_front();
        chk("result_d", 32'(od[s]), 32'(e[9:2]));
        chk("result_bout_zero", {obo[s], oz[s]}, e[1:0]);
        @(negedge clk);
        chk("after_take", {ov[s], ir[s]}, 2'b01);
        chk("held_d", 32'(od[s]), 32'(e[9:2]));
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            iv[i] = 1'b0; orr[i] = 1'b0; ta[i] = '0; tb[i] = '0; tbi[i] = 1'b0;
        end
        @(negedge clk);
        for (int i = 0; i < 4; i++)
            chk("reset_state", {ir[i], ov[i], od[i], obo[i], oz[i]}, 12'h0);
        rst = 1'b0;
        #1 chk("ready_after_release", 32'(ir[0]), 32'd1);

        do_op(0, 8'h50, 8'h20, 1'b0, 0, 0);
        do_op(1, 8'h00, 8'h00, 1'b1, 0, 0);
        do_op(1, 8'h20, 8'h50, 1'b0, 1, 0);
        do_op(0, 8'h33, 8'h33, 1'b0, 5, 0);
        do_op(0, 8'hA7, 8'h3C, 1'b1, 0, 1);
        do_op(0, 8'h00, 8'hFF, 1'b0, 2, 1);

        // Reset in the middle of an 8-digit operation; prior result must be cleared.
        @(negedge clk);
        ta[0] = 8'h9A; tb[0] = 8'h11; tbi[0] = 1'b0; iv[0] = 1'b1; orr[0] = 1'b1;
        @(negedge clk);
        iv[0] = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1 chk("midrun_reset_clear", {ov[0], od[0], obo[0], oz[0], ir[0]}, 12'h0);
        @(negedge clk);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("no_out_after_reset", 32'(ov[0]), 32'd0);
        do_op(0, 8'h9A, 8'h11, 1'b0, 0, 0);

        for (int s = 2; s < 4; s++)
            for (int x = 0; x < 8; x++)
                for (int y = 0; y < 8; y++)
                    for (int c = 0; c < 2; c++)
                        do_op(s, 8'(x), 8'(y), 1'(c), $urandom_range(0, 2), 0);

        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
